// File: rtl/simd_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simd_alu_pkg
// Description : Shared constants, operation enum and decode helpers for the
//               pipelined SIMD ALU (lane modes, ALUMODE codes, lane masks).
// Revision    : 1.0 - initial release
// ============================================================================
package simd_alu_pkg;

    // USE_SIMD lane configurations
    localparam logic [1:0] MODE_1LANE = 2'b00;
    localparam logic [1:0] MODE_2LANE = 2'b01;
    localparam logic [1:0] MODE_4LANE = 2'b10;
    localparam logic [1:0] MODE_8LANE = 2'b11;

    // Arithmetic ALUMODE codes (upper bits 00)
    localparam logic [3:0] ALU_ADD      = 4'b0000;  // Zo + T
    localparam logic [3:0] ALU_NOTZ_ADD = 4'b0001;  // ~Zo + T
    localparam logic [3:0] ALU_NOT_SUM  = 4'b0010;  // ~(Zo + T)
    localparam logic [3:0] ALU_SUB      = 4'b0011;  // Zo - T

    // ALUMODE[3:2] operation groups
    localparam logic [1:0] GRP_SUM  = 2'b00;
    localparam logic [1:0] GRP_XOR  = 2'b01;
    localparam logic [1:0] GRP_ZERO = 2'b10;
    localparam logic [1:0] GRP_LOG  = 2'b11;

    typedef enum logic [2:0] {
        OP_SUM  = 3'd0,
        OP_XOR  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_ZERO = 3'd4
    } op_e;

    // Map ALUMODE plus OPMODE[3] to the operation class
    function automatic op_e decode_op(input logic [3:0] alumode, input logic opm3);
        op_e op;
        case (alumode[3:2])
            GRP_SUM: op = OP_SUM;
            GRP_XOR: op = OP_XOR;
            GRP_LOG: op = opm3 ? OP_OR : OP_AND;
            default: op = OP_ZERO;
        endcase
        return op;
    endfunction

    // Low slice-index bits that vary inside one lane; a slice is the lane top
    // when all of these bits are set.
    function automatic logic [2:0] lane_mask(input logic [1:0] mode);
        logic [2:0] m;
        case (mode)
            MODE_1LANE: m = 3'b111;
            MODE_2LANE: m = 3'b011;
            MODE_4LANE: m = 3'b001;
            default:    m = 3'b000;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/simd_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : simd_alu_if
// Description : Operand/control/result bundle of the SIMD ALU. The master
//               drives operands and controls, the slave returns results.
// Revision    : 1.0 - initial release
// ============================================================================
interface simd_alu_if #(
    parameter int WIDTH = 32
);
    logic             ce;
    logic             in_valid;
    logic [3:0]       ALUMODE;
    logic [8:0]       OPMODE;
    logic [1:0]       USE_SIMD;
    logic             acc_en;
    logic [WIDTH-1:0] W;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] Z;
    logic             CIN;
    logic [WIDTH-1:0] S;
    logic             out_valid;
    logic [7:0]       carry_out;
    logic [7:0]       overflow;

    modport master (
        output ce, in_valid, ALUMODE, OPMODE, USE_SIMD, acc_en, W, X, Y, Z, CIN,
        input  S, out_valid, carry_out, overflow
    );

    modport slave (
        input  ce, in_valid, ALUMODE, OPMODE, USE_SIMD, acc_en, W, X, Y, Z, CIN,
        output S, out_valid, carry_out, overflow
    );
endinterface
`default_nettype wire

// File: rtl/simd_alu_slice.sv
`default_nettype none
// ============================================================================
// Module      : simd_alu_slice
// Description : One SW-bit slice of the four-operand adder. Produces the
//               slice sum, a 2-bit carry for the next slice, and the signed
//               guard-bit view (sign and overflow) used when the slice is
//               the top of a lane.
// Revision    : 1.0 - initial release
// ============================================================================
module simd_alu_slice #(
    parameter int SW = 4
) (
    input  wire logic [SW-1:0] i_a,
    input  wire logic [SW-1:0] i_w,
    input  wire logic [SW-1:0] i_x,
    input  wire logic [SW-1:0] i_y,
    input  wire logic [1:0]    i_cin,
    output logic      [SW-1:0] o_sum,
    output logic      [1:0]    o_cout,
    output logic               o_ovf,
    output logic               o_sign
);

    logic [SW+1:0] w_uns;
    logic [2:0]    w_nneg;
    logic [2:0]    w_guard;
    logic [3:0]    w_top4;

    // Four operands plus a carry of up to 3 never exceed SW+2 bits
    assign w_uns = {2'b00, i_a} + {2'b00, i_w} + {2'b00, i_x} + {2'b00, i_y}
                 + {{SW{1'b0}}, i_cin};

    // Signed result = unsigned result - 2^SW * (number of negative operands),
    // so the guard bits are the unsigned carry minus that count.
    assign w_nneg  = {2'b00, i_a[SW-1]} + {2'b00, i_w[SW-1]}
                   + {2'b00, i_x[SW-1]} + {2'b00, i_y[SW-1]};
    assign w_guard = {1'b0, w_uns[SW+1:SW]} - w_nneg;
    assign w_top4  = {w_guard, w_uns[SW-1]};

    assign o_sum  = w_uns[SW-1:0];
    assign o_cout = w_uns[SW+1:SW];
    assign o_ovf  = ~((&w_top4) | ~(|w_top4));
    assign o_sign = w_guard[2];

endmodule
`default_nettype wire

// File: rtl/simd_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : simd_alu_pipe
// Description : Two-stage SIMD ALU. Stage 1 registers operands and controls,
//               stage 2 computes W+X+Y+Z+CIN style sums or bitwise ops across
//               1/2/4/8 lanes and registers S with per-lane carry/overflow.
//               Optional macro SIMD_ALU_SATURATE_EN saturates overflowing
//               lanes for ALUMODE 0000/0011.
// Revision    : 1.0 - initial release
// ============================================================================
module simd_alu_pipe
    import simd_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic  clk,
    input  wire logic  reset,
    simd_alu_if.slave  bus
);

    localparam int SW = WIDTH / 8;

    // Stage 1
    logic [WIDTH-1:0] r_w, r_x, r_y, r_z;
    logic [3:0]       r_alumode;
    logic             r_opm3;
    logic [1:0]       r_mode;
    logic             r_acc;
    logic             r_cin;
    logic             r_v1;

    // Stage 2
    logic [WIDTH-1:0] r_s;
    logic [7:0]       r_co;
    logic [7:0]       r_ov;
    logic             r_out_valid;

    // Stage-2 combinational
    logic [WIDTH-1:0] w_zo;
    logic [WIDTH-1:0] w_a;
    op_e              w_op;
    logic             w_inv_z;
    logic             w_inv_out;
    logic             w_is_sat_op;
    logic [2:0]       w_mask;
    logic [7:0]       w_lane_top;
    logic [WIDTH-1:0] w_sum_all;
    logic [7:0]       w_cout_lsb;
    logic [7:0]       w_ovf_sl;
    logic [7:0]       w_sign_sl;
    logic [WIDTH-1:0] w_arith;
    logic [SW-1:0]    w_slice;
    logic [7:0]       w_carry;
    logic [7:0]       w_ovf;
    logic [WIDTH-1:0] w_next_s;
    logic [7:0]       w_next_co;
    logic [7:0]       w_next_ov;
    logic             w_unused_bits;
`ifdef SIMD_ALU_SATURATE_EN
    logic [2:0]       w_top_idx;
    logic             w_lane_ovf;
    logic             w_lane_sign;
`endif

    // Accumulation reads the live S register, so back-to-back ops chain
    assign w_zo        = r_acc ? r_s : r_z;
    assign w_op        = decode_op(r_alumode, r_opm3);
    assign w_inv_z     = (r_alumode == ALU_NOTZ_ADD) || (r_alumode == ALU_SUB);
    assign w_inv_out   = (r_alumode == ALU_NOT_SUM)  || (r_alumode == ALU_SUB);
    assign w_is_sat_op = (r_alumode == ALU_ADD)      || (r_alumode == ALU_SUB);
    assign w_a         = w_inv_z ? ~w_zo : w_zo;
    assign w_mask      = lane_mask(r_mode);

    // Flag which slices carry the MSB of their lane
    always_comb begin
        w_lane_top = '0;
        for (int i = 0; i < 8; i++) begin
            w_lane_top[i] = ((3'(i) & w_mask) == w_mask);
        end
    end

    // Slice array; the carry is cut wherever a new lane begins
    for (genvar gi = 0; gi < 8; gi++) begin : g_slice
        logic [1:0] w_cin;
        logic [1:0] w_cout;

        if (gi == 0) begin : g_first
            assign w_cin = {1'b0, r_cin};
        end else begin : g_chain
            assign w_cin = w_lane_top[gi-1] ? 2'b00 : g_slice[gi-1].w_cout;
        end

        simd_alu_slice #(.SW(SW)) u_slice (
            .i_a    (w_a[gi*SW +: SW]),
            .i_w    (r_w[gi*SW +: SW]),
            .i_x    (r_x[gi*SW +: SW]),
            .i_y    (r_y[gi*SW +: SW]),
            .i_cin  (w_cin),
            .o_sum  (w_sum_all[gi*SW +: SW]),
            .o_cout (w_cout),
            .o_ovf  (w_ovf_sl[gi]),
            .o_sign (w_sign_sl[gi])
        );

        assign w_cout_lsb[gi] = w_cout[0];
    end

    // Only bit 3 of OPMODE matters; the last slice's upper carry leaves the word
    assign w_unused_bits = ^{bus.OPMODE[8:4], bus.OPMODE[2:0], g_slice[7].w_cout[1]};

    // Arithmetic result with optional per-lane saturation and lane-top flags
    always_comb begin
        w_arith = '0;
        w_slice = '0;
        w_carry = '0;
        w_ovf   = '0;
`ifdef SIMD_ALU_SATURATE_EN
        w_top_idx   = '0;
        w_lane_ovf  = 1'b0;
        w_lane_sign = 1'b0;
`endif
        for (int i = 0; i < 8; i++) begin
            w_slice = w_sum_all[i*SW +: SW] ^ {SW{w_inv_out}};
`ifdef SIMD_ALU_SATURATE_EN
            w_top_idx   = 3'(i) | w_mask;
            w_lane_ovf  = w_is_sat_op & w_ovf_sl[w_top_idx];
            w_lane_sign = w_sign_sl[w_top_idx] ^ w_inv_out;
            if (w_lane_ovf) begin
                w_slice = (3'(i) == w_top_idx) ? {~w_lane_sign, {(SW-1){w_lane_sign}}}
                                               : {SW{w_lane_sign}};
            end
`endif
            w_arith[i*SW +: SW] = w_slice;
            if (w_lane_top[i]) begin
                w_carry[i] = w_cout_lsb[i];
                w_ovf[i]   = w_is_sat_op & w_ovf_sl[i];
            end
        end
    end

    // Select the stage-2 result by operation class
    always_comb begin
        w_next_s  = '0;
        w_next_co = '0;
        w_next_ov = '0;
        case (w_op)
            OP_SUM: begin
                w_next_s  = w_arith;
                w_next_co = w_carry;
                w_next_ov = w_ovf;
            end
            OP_XOR:  w_next_s = r_x ^ w_zo;
            OP_AND:  w_next_s = r_x & w_zo;
            OP_OR:   w_next_s = r_x | w_zo;
            default: w_next_s = '0;
        endcase
    end

    // Pipeline registers: stage 1 follows ce, stage 2 loads only valid results
    always_ff @(posedge clk) begin
        if (reset) begin
            r_w         <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_alumode   <= '0;
            r_opm3      <= 1'b0;
            r_mode      <= '0;
            r_acc       <= 1'b0;
            r_cin       <= 1'b0;
            r_v1        <= 1'b0;
            r_s         <= '0;
            r_co        <= '0;
            r_ov        <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (bus.ce) begin
                r_w       <= bus.W;
                r_x       <= bus.X;
                r_y       <= bus.Y;
                r_z       <= bus.Z;
                r_alumode <= bus.ALUMODE;
                r_opm3    <= bus.OPMODE[3];
                r_mode    <= bus.USE_SIMD;
                r_acc     <= bus.acc_en;
                r_cin     <= bus.CIN;
                r_v1      <= bus.in_valid;
            end
            if (bus.ce && r_v1) begin
                r_s  <= w_next_s;
                r_co <= w_next_co;
                r_ov <= w_next_ov;
            end
            r_out_valid <= bus.ce & r_v1;
        end
    end

    assign bus.S         = r_s;
    assign bus.carry_out = r_co;
    assign bus.overflow  = r_ov;
    assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: doc/simd_alu_pipe.md
# simd_alu_pipe

Pipelined, width-parametrised SIMD ALU for the PIRDSP post-multiplier path. It adds W+X+Y+Z+CIN, with DSP48-style negate/subtract variants, or applies XOR/AND/OR, across 1, 2, 4 or 8 independent lanes selected by USE_SIMD. A registered accumulator feedback replaces Z with the previous result, and each lane reports carry and signed overflow. It sits between the multiplier partial-product outputs and the output register bank.

## Interface
Parameters:
- WIDTH, 32 — datapath width; multiple of 8, minimum 16; slice width SW = WIDTH/8.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  — sole clock, rising edge.
- reset  in  1  — synchronous, active-high; clears every register.
- ce  in  1  — clock enable for all pipeline registers.
- in_valid  in  1  — operand set valid this cycle.
- ALUMODE  in  4  — operation select.
- OPMODE  in  9  — only bit 3 used (AND/OR select).
- USE_SIMD  in  2  — 00: 1 lane of WIDTH; 01: 2 lanes of WIDTH/2; 10: 4 lanes of WIDTH/4; 11: 8 lanes of SW.
- acc_en  in  1  — replace Z with the current S register.
- W, X, Y, Z  in  WIDTH  — operands.
- CIN  in  1  — carry in; applies to lane 0 only.
- S  out  WIDTH  — registered result.
- out_valid  out  1  — S updated this cycle.
- carry_out  out  8  — per-slice flag; valid only at each lane-top slice, 0 elsewhere.
- overflow  out  8  — per-slice signed-overflow flag, lane-top slices only.

## Operation
- Stage 1 registers the operands and the ALUMODE/OPMODE/USE_SIMD/acc_en/CIN controls whenever ce=1; its valid bit is v1 <= in_valid. Controls always travel with their data.
- Stage 2 computes the result and, when ce=1 and v1=1, loads S, carry_out and overflow; out_valid <= ce & v1.
- Z operand Zo = acc_en ? S : Z. The S register always holds the last valid result, so back-to-back accumulation needs no bubble.
- Per lane, all arithmetic is modulo 2^LW, where LW is the lane width. No carry crosses a lane boundary. T = W+X+Y+CIN (CIN in lane 0 only):
  - 0000: Zo + T
  - 0001: ~Zo + T
  - 0010: ~(Zo + T)
  - 0011: Zo − T
  - 01xx: X ^ Zo
  - 11xx: OPMODE[3] ? X | Zo : X & Zo
  - 10xx: S = 0, all flags 0.
- carry_out (sum ops only): bit LW of the unsigned lane sum, i.e. the LSB of the carries above the lane MSB. Logic ops give 0.
- overflow (0000 and 0011 only): the exact signed lane result, computed with 3 guard bits, is not representable in LW bits. All other modes give 0.

## Timing
- Latency is 2 cycles from in_valid to out_valid at ce=1. Throughput is 1 per cycle.
- ce=0 freezes all registers, and out_valid drives 0 during the stall. Held data emerges after ce returns.
- Reset values: S=0, carry_out=0, overflow=0, out_valid=0, v1=0, stage-1 registers 0.
- Reset mid-stream drops in-flight data. The next accumulate starts from S=0.
- A USE_SIMD change between ops is legal. Accumulating across a mode change uses the old S bits reinterpreted under the new lanes.
- in_valid=0 leaves S and the flags unchanged.

## Configuration
- SIMD_ALU_SATURATE_EN defined: for ALUMODE 0000/0011, a lane with overflow=1 outputs 0111…1 (positive overflow) or 1000…0 (negative). The saturated value is what feeds accumulation.
- Undefined: results wrap; overflow is still reported.

## Structure
- Package simd_alu_pkg holds:
  - USE_SIMD constants (MODE_1LANE, MODE_2LANE, MODE_4LANE, MODE_8LANE);
  - op enum (OP_SUM, OP_XOR, OP_AND, OP_OR);
  - ALUMODE decode constants.
- Sub-module simd_alu_slice (parameter SW): one SW-bit slice taking carry-in and producing carry-out plus a guard-bit sign. Instantiate 8×, with carry muxing between slices by USE_SIMD.

## Test plan (WIDTH=32)
- Carry: mode 00, ALUMODE 0000, Z=0xFFFFFFFF, X=1, other operands 0 → S=0x00000000, carry_out[7]=1, overflow[7]=0, out_valid exactly 2 cycles after in_valid.
- Lane overflow: mode 11, ALUMODE 0000, Z=0x77777777, X=0x11111111 → S=0x88888888, carry_out=0x00, overflow=0xFF. With SIMD_ALU_SATURATE_EN → S=0x77777777.
- Subtract: mode 01, ALUMODE 0011, Z=0x00050003, X=0x00020005 → S=0x0003FFFE, overflow=0x00, with no borrow into the upper lane.
- Accumulate: after reset, mode 10, acc_en=1, X=0x01020304 on 3 consecutive valid cycles → S=0x01020304, then 0x02040608, then 0x0306090C.
- Logic: X=0xF0F0F0F0, Z=0xFF00FF00:
  - ALUMODE 1100, OPMODE[3]=0 → S=0xF000F000;
  - OPMODE[3]=1 → S=0xFFF0FFF0;
  - ALUMODE 0100 → S=0x0FF00FF0.
- Stall/reset: ce=0 for 3 cycles mid-stream → S held, out_valid=0, then the stream resumes in order. Reset during accumulation → S=0, out_valid=0 on the next edge.
